// File: rtl/twos_complement_seq_ctrl.sv
// twos_complement_seq_ctrl: streams a word LSB-first through a bit-serial negator and reassembles the result
module twos_complement_seq_ctrl #(
  parameter int W = 8,
  parameter int CONV_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_ovf_o,
  output logic         busy_o,
  output logic         conv_rst_o,
  output logic         conv_in_o,
  input  logic         conv_out_i
);
  localparam int N = W + CONV_LAT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;
  state_t state_q;
  logic [W-1:0] shift_q, res_q;
  logic [CW-1:0] cnt_q;
  logic ovf_q, valid_q, busy_q, cap, last;
  // a delayed converter produces nothing useful in the first shift cycle
  assign cap = (CONV_LAT == 0) || (cnt_q != '0);
  assign last = cnt_q == CW'(N - 1);
  assign in_ready_o = (state_q == IDLE) && !rst;
  assign conv_rst_o = rst || (state_q == CLR);
  assign conv_in_o = (state_q == SHIFT) && (cnt_q < CW'(W)) && shift_q[0];
  assign out_valid_o = valid_q;
  assign out_data_o = res_q;
  assign out_ovf_o = ovf_q;
  assign busy_o = busy_q;
  // sequencer: accept, clear converter, shift W bits through it, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          shift_q <= in_data_i;
          res_q <= '0;
          ovf_q <= in_data_i == {1'b1, {W-1{1'b0}}};
          busy_q <= 1'b1;
          state_q <= CLR;
        end
        CLR: begin
          cnt_q <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
          shift_q <= shift_q >> 1;
          if (cap) res_q <= {conv_out_i, res_q[W-1:1]};
          if (last) begin
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready_i) begin
          valid_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_twos_complement_seq_ctrl.sv
// tb_twos_complement_seq_ctrl: directed table, corner sequences and random words on W=8/LAT=0 and W=16/LAT=1
module tb_twos_complement_seq_ctrl;
  logic clk = 0, rst = 1, sel = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  logic ir0, ov0, oo0, bz0, cr0, ci0, co0, seen0;
  logic [7:0] od0;
  twos_complement_seq_ctrl #(.W(8), .CONV_LAT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid & !sel), .in_ready_o(ir0), .in_data_i(in_data[7:0]),
    .out_valid_o(ov0), .out_ready_i(out_ready & !sel), .out_data_o(od0), .out_ovf_o(oo0),
    .busy_o(bz0), .conv_rst_o(cr0), .conv_in_o(ci0), .conv_out_i(co0));
  always_ff @(posedge clk) seen0 <= cr0 ? 1'b0 : (seen0 | ci0);
  assign co0 = seen0 ? ~ci0 : ci0;

  logic ir1, ov1, oo1, bz1, cr1, ci1, co1, seen1, dly1;
  logic [15:0] od1;
  twos_complement_seq_ctrl #(.W(16), .CONV_LAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid & sel), .in_ready_o(ir1), .in_data_i(in_data),
    .out_valid_o(ov1), .out_ready_i(out_ready & sel), .out_data_o(od1), .out_ovf_o(oo1),
    .busy_o(bz1), .conv_rst_o(cr1), .conv_in_o(ci1), .conv_out_i(co1));
  always_ff @(posedge clk) begin
    seen1 <= cr1 ? 1'b0 : (seen1 | ci1);
    dly1 <= cr1 ? 1'b0 : (seen1 ? ~ci1 : ci1);
  end
  assign co1 = dly1;

  logic ir, ov, oo, ci;
  logic [15:0] od;
  assign ir = sel ? ir1 : ir0;
  assign ov = sel ? ov1 : ov0;
  assign oo = sel ? oo1 : oo0;
  assign ci = sel ? ci1 : ci0;
  assign od = sel ? od1 : {8'h00, od0};

  typedef struct {logic [7:0] d; logic [7:0] e; logic ovf; int stall;} vec_t;
  vec_t tv[6];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic run(input logic s, input logic [15:0] d, input int stall, input logic [15:0] e, input logic eo);
    int w, lat, n;
    logic [15:0] cin;
    w = s ? 16 : 8;
    sel = s;
    cin = '0;
    lat = 0;
    n = 0;
    @(negedge clk);
    while (!ir && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before", ir, 1);
    in_valid = 1;
    in_data = d;
    out_ready = (stall == 0);
    @(posedge clk);
    #1 in_valid = 0;
    in_data = ~d;
    do begin
      @(negedge clk);
      lat++;
      if (lat >= 2 && lat < w + 2) cin[lat-2] = ci;
    end while (!ov && lat < 60);
    chk("latency", lat, w + 2 + (s ? 1 : 0));
    chk("out_data", od, e);
    chk("out_ovf", oo, eo);
    chk("conv_in_seq", cin, s ? d : {8'h00, d[7:0]});
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", ov, 1);
      chk("stall_data", od, e);
      chk("stall_in_ready", ir, 0);
      @(negedge clk);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("valid_dropped", ov, 0);
    chk("in_ready_after", ir, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d8, e8;
    logic [15:0] d16, e16;
    int hits;
    tv[0] = '{8'h05, 8'hFB, 1'b0, 0};
    tv[1] = '{8'h00, 8'h00, 1'b0, 0};
    tv[2] = '{8'h80, 8'h80, 1'b1, 0};
    tv[3] = '{8'hFF, 8'h01, 1'b0, 0};
    tv[4] = '{8'h7F, 8'h81, 1'b0, 0};
    tv[5] = '{8'h2C, 8'hD4, 1'b0, 5};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_conv_rst", cr0, 1);
    chk("rst_in_ready", ir0, 0);
    chk("rst_out_data", od0, 0);
    chk("rst_conv_in", ci0, 0);
    rst = 0;
    #1 chk("post_rst_in_ready", ir0, 1);
    for (int i = 0; i < 6; i++) run(0, {8'h00, tv[i].d}, tv[i].stall, {8'h00, tv[i].e}, tv[i].ovf);
    sel = 0;
    @(negedge clk);
    in_valid = 1;
    in_data = 16'h0033;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_busy", bz0, 0);
    chk("abort_valid", ov0, 0);
    chk("abort_in_ready", ir0, 0);
    chk("abort_conv_rst", cr0, 1);
    rst = 0;
    hits = 0;
    repeat (15) begin
      @(negedge clk);
      if (ov0) hits++;
    end
    chk("abort_no_valid", hits, 0);
    run(0, 16'h0001, 0, 16'h00FF, 0);
    run(1, 16'h0005, 0, 16'hFFFB, 0);
    run(1, 16'h8000, 2, 16'h8000, 1);
    run(1, 16'h0000, 0, 16'h0000, 0);
    for (int i = 0; i < 100; i++) begin
      d8 = 8'($urandom);
      e8 = ~d8 + 8'd1;
      run(0, {8'h00, d8}, 0, {8'h00, e8}, d8 == 8'h80);
      d16 = 16'($urandom);
      e16 = ~d16 + 16'd1;
      run(1, d16, 0, e16, d16 == 16'h8000);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
